prog_rom_arbiter: RTL and testbench
===================================

Name: prog_rom_arbiter

Overview:
- Shares the single synchronous-read 1024x18 program memory between two requesters:
  - the MCU instruction-fetch port (F);
  - a debug/loader port (D), which can read the program or write it.
- Sits between the MCU program counter logic and the program memory instance.
- Fetch has priority. A bounded-wait counter guarantees debug access.
- Read data returns one cycle after grant, matching the memory's registered output.

Parameters:
- ADDR_W, 10, program memory address width (1024 words).
- DATA_W, 18, instruction word width.
- MAX_WAIT, 4, consecutive denied debug cycles after which debug wins the next arbitration (range 1..15).

Ports:
- PROG_CLK  in  1  single clock, rising edge.
- PROG_RST_N  in  1  asynchronous, active-low reset.
- F_REQ  in  1  fetch request, one read per cycle, may be held.
- F_ADDR  in  ADDR_W  fetch address.
- F_GNT  out  1  fetch granted this cycle (combinational).
- F_STALL  out  1  = F_REQ & ~F_GNT.
- F_VALID  out  1  fetch data valid (cycle after F_GNT).
- F_DATA  out  DATA_W  fetch instruction word.
- DBG_REQ  in  1  debug request, held until DBG_ACK.
- DBG_WE  in  1  1 = write, 0 = read; stable while DBG_REQ is high.
- DBG_ADDR  in  ADDR_W  debug address.
- DBG_WDATA  in  DATA_W  debug write data.
- DBG_ACK  out  1  one-cycle pulse completing a debug transaction.
- DBG_RDATA  out  DATA_W  debug read data, valid with DBG_ACK on reads.
- MEM_ADDR  out  ADDR_W  memory address.
- MEM_WE  out  1  memory write enable.
- MEM_WDATA  out  DATA_W  memory write data.
- MEM_RDATA  in  DATA_W  memory output, registered, valid the cycle after its address.

Behaviour:
- Reset (async assert, sync release):
  - owner register = NONE, dbg_pend = 0, wait_cnt = 0.
  - F_VALID = 0, DBG_ACK = 0.
  - F_DATA = 0, DBG_RDATA = 0: both are data-gated, so they read 0 whenever invalid.
  - While PROG_RST_N is low: F_GNT = 0, MEM_WE = 0, MEM_ADDR = 0.
- Debug eligibility: dbg_elig = DBG_REQ & ~dbg_pend.
  - dbg_pend is 1 in the cycle after a debug grant.
  - This blocks a re-grant while the requester is still seeing its ACK.
- Arbitration, combinational each cycle:
  - if dbg_elig & (wait_cnt == MAX_WAIT | ~F_REQ): grant D;
  - else if F_REQ: grant F;
  - else: no grant.
- On grant F: MEM_ADDR = F_ADDR, MEM_WE = 0.
- On grant D: MEM_ADDR = DBG_ADDR, MEM_WE = DBG_WE, MEM_WDATA = DBG_WDATA.
- No grant: MEM_ADDR holds its last registered value, MEM_WE = 0.
- Owner register samples the grant each edge: NONE / F / D_RD / D_WR.
- Response cycle:
  - owner F: F_VALID = 1, F_DATA = MEM_RDATA.
  - owner D_RD: DBG_ACK = 1, DBG_RDATA = MEM_RDATA.
  - owner D_WR: DBG_ACK = 1, DBG_RDATA = 0.
- Latency:
  - fetch is 1 cycle, fully pipelined (back-to-back grants give back-to-back F_VALID);
  - debug is grant+1, at most one debug transaction in flight.
- wait_cnt:
  - increments (saturating at MAX_WAIT) each cycle dbg_elig is high and F is granted;
  - clears on a D grant or when DBG_REQ is low.
- Simultaneous requests:
  - fetch wins until wait_cnt reaches MAX_WAIT;
  - then D wins exactly one cycle and fetch stalls that cycle.
- Write/read same address in consecutive cycles: the arbiter does no forwarding; memory read-after-write ordering governs.
- Reset mid-transaction: in-flight responses are discarded, with no F_VALID or DBG_ACK after reset release.
- DBG_REQ dropped before ACK is a protocol violation. The arbiter still completes any granted transaction and pulses ACK.

Test Plan:
- Fetch stream: F_REQ=1, F_ADDR=0,1,2,3 on consecutive cycles, DBG_REQ=0 -> F_GNT=1 each cycle; F_VALID=1 one cycle later with rom[0..3]; F_STALL=0 throughout.
- Debug read idle: F_REQ=0, DBG_REQ=1, DBG_WE=0, DBG_ADDR=0x3FF -> MEM_ADDR=0x3FF in the grant cycle; next cycle DBG_ACK=1, DBG_RDATA=rom[0x3FF]; requester drops REQ; no second grant.
- Starvation bound: F_REQ=1 continuously, DBG_REQ=1 (write, addr 0x010, data 0x2ABCD), MAX_WAIT=4 -> fetch granted 4 cycles; 5th cycle D granted with MEM_WE=1 and F_STALL=1; DBG_ACK the next cycle; a subsequent read of 0x010 returns 0x2ABCD.
- Held DBG_REQ across ACK: DBG_REQ held high one extra cycle after ACK with F_REQ=0 -> no re-grant in the ACK cycle (dbg_pend); a new grant only if REQ is still high the cycle after.
- Reset mid-op: assert PROG_RST_N=0 in the cycle after a D grant -> DBG_ACK, F_VALID, MEM_WE all 0 immediately; after release, no stale ACK and wait_cnt=0.
- Idle: no requests for 10 cycles -> MEM_WE=0, F_VALID=0, DBG_ACK=0, MEM_ADDR unchanged.

Source files
------------

// File: rtl/prog_rom_arbiter.sv
// prog_rom_arbiter
// Shares one synchronous-read program memory between the MCU instruction
// fetch port (F) and a debug/loader port (D). Fetch has priority; a
// saturating wait counter lets a starved debug request win one cycle once it
// has been denied MAX_WAIT times in a row. Read data comes back the cycle
// after the grant, straight from the memory's registered output.
//
// Owner register (who receives the memory output in the next cycle):
//   state      | meaning
//   OWN_NONE   | no access last cycle, no response this cycle
//   OWN_F      | fetch granted last cycle, F_VALID this cycle
//   OWN_D_RD   | debug read granted last cycle, DBG_ACK with read data
//   OWN_D_WR   | debug write granted last cycle, DBG_ACK with zero data

module prog_rom_arbiter #(
   parameter int ADDR_W   = 10,
   parameter int DATA_W   = 18,
   parameter int MAX_WAIT = 4
) (
   input  logic              PROG_CLK,
   input  logic              PROG_RST_N,
   // fetch port
   input  logic              F_REQ,
   input  logic [ADDR_W-1:0] F_ADDR,
   output logic              F_GNT,
   output logic              F_STALL,
   output logic              F_VALID,
   output logic [DATA_W-1:0] F_DATA,
   // debug/loader port
   input  logic              DBG_REQ,
   input  logic              DBG_WE,
   input  logic [ADDR_W-1:0] DBG_ADDR,
   input  logic [DATA_W-1:0] DBG_WDATA,
   output logic              DBG_ACK,
   output logic [DATA_W-1:0] DBG_RDATA,
   // program memory
   output logic [ADDR_W-1:0] MEM_ADDR,
   output logic              MEM_WE,
   output logic [DATA_W-1:0] MEM_WDATA,
   input  logic [DATA_W-1:0] MEM_RDATA
);

   localparam int CNT_W = 4;
   localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_F    = 2'd1,
      OWN_D_RD = 2'd2,
      OWN_D_WR = 2'd3
   } owner_e;

   owner_e            owner_q, owner_d;
   logic              dbg_pend_q, dbg_pend_d;
   logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

   logic              dbg_elig;
   logic              gnt_d;
   logic              gnt_f;

   // Arbitration: debug wins when fetch is idle or debug has waited long
   // enough. Grants are suppressed while reset is held so the memory sees
   // no access during reset.
   always_comb begin
      dbg_elig = DBG_REQ & ~dbg_pend_q;
      gnt_d    = 1'b0;
      gnt_f    = 1'b0;
      if (PROG_RST_N) begin
         if (dbg_elig && ((wait_cnt_q == WAIT_LIMIT) || !F_REQ)) begin
            gnt_d = 1'b1;
         end else if (F_REQ) begin
            gnt_f = 1'b1;
         end
      end
   end

   // Memory port steering; the address holds its last granted value when
   // nobody owns the cycle, which keeps the memory input quiet when idle.
   always_comb begin
      mem_addr_d = mem_addr_q;
      MEM_WE     = 1'b0;
      if (gnt_d) begin
         mem_addr_d = DBG_ADDR;
         MEM_WE     = DBG_WE;
      end else if (gnt_f) begin
         mem_addr_d = F_ADDR;
      end
   end

   assign MEM_ADDR  = mem_addr_d;
   assign MEM_WDATA = DBG_WDATA;

   // Next-state for owner, debug pending flag and the starvation counter.
   always_comb begin
      owner_d    = OWN_NONE;
      dbg_pend_d = gnt_d;
      wait_cnt_d = wait_cnt_q;

      if (gnt_f) begin
         owner_d = OWN_F;
      end else if (gnt_d) begin
         owner_d = DBG_WE ? OWN_D_WR : OWN_D_RD;
      end

      // The counter only tracks an eligible debug request that lost to
      // fetch; a held request during its own ACK cycle neither counts nor
      // clears.
      if (gnt_d || !DBG_REQ) begin
         wait_cnt_d = '0;
      end else if (dbg_elig && gnt_f && (wait_cnt_q != WAIT_LIMIT)) begin
         wait_cnt_d = wait_cnt_q + 1'b1;
      end
   end

   // State registers; reset discards any in-flight response.
   always_ff @(posedge PROG_CLK or negedge PROG_RST_N) begin
      if (!PROG_RST_N) begin
         owner_q    <= OWN_NONE;
         dbg_pend_q <= 1'b0;
         wait_cnt_q <= '0;
         mem_addr_q <= '0;
      end else begin
         owner_q    <= owner_d;
         dbg_pend_q <= dbg_pend_d;
         wait_cnt_q <= wait_cnt_d;
         mem_addr_q <= mem_addr_d;
      end
   end

   // Response side: data outputs are gated so they read zero when invalid.
   always_comb begin
      F_GNT     = gnt_f;
      F_STALL   = F_REQ & ~gnt_f;
      F_VALID   = (owner_q == OWN_F);
      F_DATA    = '0;
      DBG_ACK   = (owner_q == OWN_D_RD) || (owner_q == OWN_D_WR);
      DBG_RDATA = '0;
      if (owner_q == OWN_F) begin
         F_DATA = MEM_RDATA;
      end
      if (owner_q == OWN_D_RD) begin
         DBG_RDATA = MEM_RDATA;
      end
   end

endmodule

// File: tb/tb_prog_rom_arbiter.sv
// Bench for prog_rom_arbiter: a 1024x18 synchronous-read memory next to the
// DUT, directed scenarios followed by random traffic, all checked against a
// transaction-level model of the arbitration rules.

module tb_prog_rom_arbiter;

   localparam int AW = 10;
   localparam int DW = 18;
   localparam int MW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          f_req = 1'b0;
   logic [AW-1:0] f_addr = '0;
   logic          f_gnt, f_stall, f_valid;
   logic [DW-1:0] f_data;
   logic          dbg_req = 1'b0;
   logic          dbg_we = 1'b0;
   logic [AW-1:0] dbg_addr = '0;
   logic [DW-1:0] dbg_wdata = '0;
   logic          dbg_ack;
   logic [DW-1:0] dbg_rdata;
   logic [AW-1:0] mem_addr;
   logic          mem_we;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata = '0;

   logic [DW-1:0] mem     [0:1023];
   logic [DW-1:0] ref_rom [0:1023];

   int n_pass = 0;
   int n_chk  = 0;

   // model state
   int            denied;
   bit            pend;
   logic [AW-1:0] last_addr;
   bit            exp_fv, exp_ack;
   logic [DW-1:0] exp_fd, exp_rd;
   bit            p_gd, p_gf;
   // DUT observations of the last cycle, used for counting only
   bit            obs_fgnt, obs_we, obs_stall;

   always #5 clk = ~clk;

   prog_rom_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
      .PROG_CLK   (clk),
      .PROG_RST_N (rst_n),
      .F_REQ      (f_req),
      .F_ADDR     (f_addr),
      .F_GNT      (f_gnt),
      .F_STALL    (f_stall),
      .F_VALID    (f_valid),
      .F_DATA     (f_data),
      .DBG_REQ    (dbg_req),
      .DBG_WE     (dbg_we),
      .DBG_ADDR   (dbg_addr),
      .DBG_WDATA  (dbg_wdata),
      .DBG_ACK    (dbg_ack),
      .DBG_RDATA  (dbg_rdata),
      .MEM_ADDR   (mem_addr),
      .MEM_WE     (mem_we),
      .MEM_WDATA  (mem_wdata),
      .MEM_RDATA  (mem_rdata)
   );

   // synchronous-read program memory
   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   task automatic model_reset();
      denied    = 0;
      pend      = 1'b0;
      last_addr = '0;
      exp_fv    = 1'b0;
      exp_ack   = 1'b0;
      exp_fd    = '0;
      exp_rd    = '0;
   endtask

   // One clock cycle: entered 1ns after a rising edge with inputs set,
   // checks at the falling edge, advances the model at the next rising edge.
   task automatic cycle();
      bit            elig;
      bit            ewe;
      logic [AW-1:0] ea;
      @(negedge clk);
      elig = dbg_req && !pend;
      p_gd = elig && ((denied == MW) || !f_req);
      p_gf = !p_gd && f_req;
      ea   = p_gd ? dbg_addr : (p_gf ? f_addr : last_addr);
      ewe  = p_gd && dbg_we;
      chk("f_gnt",    f_gnt,    p_gf);
      chk("f_stall",  f_stall,  f_req && !p_gf);
      chk("mem_addr", mem_addr, ea);
      chk("mem_we",   mem_we,   ewe);
      if (ewe) chk("mem_wdata", mem_wdata, dbg_wdata);
      chk("f_valid",  f_valid,  exp_fv);
      chk("f_data",   f_data,   exp_fv ? exp_fd : '0);
      chk("dbg_ack",  dbg_ack,  exp_ack);
      chk("dbg_rdata", dbg_rdata, exp_ack ? exp_rd : '0);
      obs_fgnt  = f_gnt;
      obs_we    = mem_we;
      obs_stall = f_stall;
      @(posedge clk);
      exp_fv  = p_gf;
      exp_ack = p_gd;
      if (p_gf) exp_fd = ref_rom[f_addr];
      if (p_gd) begin
         if (dbg_we) begin
            exp_rd = '0;
            ref_rom[dbg_addr] = dbg_wdata;
         end else begin
            exp_rd = ref_rom[dbg_addr];
         end
      end
      if (p_gd || !dbg_req) denied = 0;
      else if (elig && p_gf && denied < MW) denied++;
      pend      = p_gd;
      last_addr = ea;
      #1;
   endtask

   initial begin
      int nf;
      bit got;

      for (int i = 0; i < 1024; i++) begin
         mem[i]     = DW'($urandom);
         ref_rom[i] = mem[i];
      end
      model_reset();

      // reset state, with a fetch request pending to show grants are held off
      f_req = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("rst_f_valid",   f_valid,   0);
      chk("rst_dbg_ack",   dbg_ack,   0);
      chk("rst_f_data",    f_data,    0);
      chk("rst_dbg_rdata", dbg_rdata, 0);
      chk("rst_mem_addr",  mem_addr,  0);
      chk("rst_mem_we",    mem_we,    0);
      chk("rst_f_gnt",     f_gnt,     0);
      f_req = 1'b0;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // fetch stream 0..3
      f_req = 1'b1;
      for (int i = 0; i < 4; i++) begin
         f_addr = AW'(i);
         cycle();
         chk("fs_nostall", obs_stall, 0);
      end
      f_req = 1'b0;
      cycle();

      // debug read at the top address, fetch idle
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 10'h3FF;
      cycle();
      chk("dr_ack_now", dbg_ack, 1);
      chk("dr_rdata_now", dbg_rdata, mem[10'h3FF]);
      dbg_req = 1'b0;
      cycle();
      cycle();

      // starvation bound: continuous fetch against a debug write
      f_req = 1'b1;
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 10'h010; dbg_wdata = 18'h2ABCD;
      nf = 0; got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         f_addr = AW'($urandom);
         cycle();
         if (obs_we) begin
            got = 1'b1;
            chk("starve_stall", obs_stall, 1);
         end else if (obs_fgnt) nf++;
      end
      chk("starve_dwin", got, 1);
      chk("starve_fetches", nf, MW);
      dbg_req = 1'b0;
      cycle();
      f_req = 1'b0;
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 10'h010;
      cycle();
      chk("rdback_ack", dbg_ack, 1);
      chk("rdback_data", dbg_rdata, 18'h2ABCD);
      dbg_req = 1'b0;
      cycle();

      // request held across ACK: blocked in the ACK cycle, re-granted after
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = AW'($urandom);
      cycle();
      cycle();
      chk("held_no_regrant", obs_fgnt | obs_we | dbg_ack, 0);
      cycle();
      dbg_req = 1'b0;
      cycle();

      // reset in the cycle after a debug write grant
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = AW'($urandom); dbg_wdata = DW'($urandom);
      cycle();
      rst_n = 1'b0;
      #1;
      chk("rmid_ack",      dbg_ack,  0);
      chk("rmid_f_valid",  f_valid,  0);
      chk("rmid_mem_we",   mem_we,   0);
      chk("rmid_mem_addr", mem_addr, 0);
      model_reset();
      dbg_req = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      cycle();
      // wait counter must restart from zero
      f_req = 1'b1;
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = AW'($urandom);
      nf = 0; got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         f_addr = AW'($urandom);
         cycle();
         if (dbg_ack) got = 1'b1;
         else if (obs_fgnt) nf++;
      end
      chk("rpost_dwin", got, 1);
      chk("rpost_fetches", nf, MW);
      dbg_req = 1'b0;
      f_req = 1'b0;
      cycle();

      // idle
      for (int i = 0; i < 10; i++) cycle();

      // random traffic
      for (int n = 0; n < 3000; n++) begin
         f_req  = ($urandom_range(0, 3) != 0);
         f_addr = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 15)) : AW'($urandom);
         if (dbg_req && dbg_ack) begin
            if ($urandom_range(0, 3) != 0) dbg_req = 1'b0;
         end else if (!dbg_req && $urandom_range(0, 2) == 0) begin
            dbg_req   = 1'b1;
            dbg_we    = $urandom_range(0, 1) != 0;
            dbg_addr  = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 15)) : AW'($urandom);
            dbg_wdata = DW'($urandom);
         end
         cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
